// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide
// sequencer (muldiv_ctrl and muldiv_step).
//   - Op encodings carried on the 2-bit Op port
//   - Sequencer state enum
//   - ALU operation codes (must equal the alu ALUControl encodings)
//   - Iteration count
package muldiv_pkg;

    localparam logic [1:0] MULDIV_MUL   = 2'b00;
    localparam logic [1:0] MULDIV_MULHU = 2'b01;
    localparam logic [1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of shift-add multiply or restoring divide.
// Purely combinational; the ALU sum/difference and carry are supplied by the
// shared alu, operands having been routed there by muldiv_ctrl.
// Ports:
//   is_div     in   1   0: multiply step (hi=Hi, lo=Lo), 1: divide step (hi=R, lo=Q)
//   hi, lo     in  32   current iteration registers
//   alu_result in  32   Hi+M (multiply) or R'-D (divide)
//   c          in   1   alu carry; for SUB, 1 means no borrow
//   hi_next    out 32   next Hi / R
//   lo_next    out 32   next Lo / Q
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] alu_result,
    input  logic        c,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next
);

    logic [31:0] r_shift;
    logic        qbit;

    always_comb begin
        r_shift = {hi[30:0], lo[31]};
        // R[31] set means the shifted remainder already exceeds 32 bits,
        // so the subtraction must succeed even though C reports a borrow.
        qbit    = hi[31] | c;
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            hi_next = qbit ? alu_result : r_shift;
            lo_next = {lo[30:0], qbit};
        end else if (lo[0]) begin
            hi_next = {c, alu_result[31:1]};
            lo_next = {alu_result[0], lo[31:1]};
        end else begin
            hi_next = {1'b0, hi[31:1]};
            lo_next = {hi[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MUL/MULHU/DIVU/REMU sequencer that borrows the EX
// stage alu for its add/subtract. Busy stalls the pipeline; Done pulses for
// one cycle with Result valid; Result holds until the next accepted Start.
// Optional build macro: MULDIV_EARLY_OUT_EN (zero-operand ops finish in 1 cycle).
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   Start, Op            request (sampled in IDLE) and operation select
//   SrcA, SrcB           multiplicand/dividend, multiplier/divisor
//   Busy, Done, Result   status and final value
//   ALUOwn               EX mux selects controller operands while high
//   ALUControl           ALU_ADD or ALU_SUB
//   ALUSrcA, ALUSrcB     alu operands
//   ALUResult, C         alu result and carry
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic        ALUOwn,
    output logic [3:0]  ALUControl,
    output logic [31:0] ALUSrcA,
    output logic [31:0] ALUSrcB,
    input  logic [31:0] ALUResult,
    input  logic        C
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERS - 1);

    muldiv_state_t state;
    logic [1:0]    op_q;
    logic [4:0]    cnt;
    logic [31:0]   hi;      // Hi (multiply) or R (divide)
    logic [31:0]   lo;      // Lo (multiply) or Q (divide)
    logic [31:0]   m;       // M (multiply) or D (divide)
    logic [31:0]   result_q;
    logic [31:0]   hi_next;
    logic [31:0]   lo_next;
    logic          is_div;

    assign is_div = op_q[1];

    muldiv_step u_step (
        .is_div     (is_div),
        .hi         (hi),
        .lo         (lo),
        .alu_result (ALUResult),
        .c          (C),
        .hi_next    (hi_next),
        .lo_next    (lo_next)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic        early_hit;
    logic [31:0] early_value;

    always_comb begin
        if (Op[1]) begin
            early_hit   = (SrcB == '0);
            early_value = Op[0] ? SrcA : '1;
        end else begin
            early_hit   = (SrcA == '0) || (SrcB == '0);
            early_value = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q <= Op;
                        cnt  <= '0;
                        hi   <= '0;
                        lo   <= Op[1] ? SrcA : SrcB;
                        m    <= Op[1] ? SrcB : SrcA;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            state    <= DONE;
                            result_q <= early_value;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state    <= DONE;
                        // MULHU/REMU (Op[0]=1) return Hi/R, MUL/DIVU return Lo/Q.
                        result_q <= op_q[0] ? hi_next : lo_next;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Busy       = (state != IDLE);
        Done       = (state == DONE);
        ALUOwn     = (state == RUN);
        Result     = result_q;
        ALUControl = ALU_ADD;
        ALUSrcA    = '0;
        ALUSrcB    = '0;
        if (state == RUN) begin
            ALUControl = is_div ? ALU_SUB : ALU_ADD;
            ALUSrcA    = is_div ? {hi[30:0], lo[31]} : hi;
            ALUSrcB    = m;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl with a behavioural alu
// and a reference model using plain 64-bit arithmetic.
// Honours MULDIV_EARLY_OUT_EN for expected latencies.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA, SrcB;
    logic        Busy, Done, ALUOwn, C;
    logic [31:0] Result, ALUSrcA, ALUSrcB, ALUResult;
    logic [3:0]  ALUControl;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .Op         (Op),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result),
        .ALUOwn     (ALUOwn),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUResult  (ALUResult),
        .C          (C)
    );

    // Behavioural alu: 33-bit add, or A + ~B + 1 so that carry = no borrow.
    logic [32:0] alu_wide;
    always_comb begin
        if (ALUControl == ALU_SUB)
            alu_wide = {1'b0, ALUSrcA} + {1'b0, ~ALUSrcB} + 33'd1;
        else
            alu_wide = {1'b0, ALUSrcA} + {1'b0, ALUSrcB};
    end
    assign ALUResult = alu_wide[31:0];
    assign C         = alu_wide[32];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] exp;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            MULDIV_MUL:   return p[31:0];
            MULDIV_MULHU: return p[63:32];
            MULDIV_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:      return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op[1] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
        return 33;
    endfunction

    // Monitor: samples on the falling edge, pops on Done.
    int          busy_cnt = 0;
    int          own_cnt = 0;
    logic [31:0] hold = '0;

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
            own_cnt  = 0;
            hold     = '0;
        end else begin
            if (Busy)   busy_cnt++;
            if (ALUOwn) own_cnt++;
            if (!ALUOwn) begin
                chk("idle_alu_ctl", {28'd0, ALUControl}, {28'd0, ALU_ADD});
                chk("idle_alu_a", ALUSrcA, '0);
                chk("idle_alu_b", ALUSrcB, '0);
            end else if (sb.size() > 0) begin
                chk("run_alu_ctl", {28'd0, ALUControl},
                    {28'd0, (sb[0].op[1] ? ALU_SUB : ALU_ADD)});
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", Result, e.exp);
                    chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                    chk("aluown_cycles", 32'(own_cnt), (e.lat == 1) ? 32'd0 : 32'd32);
                    hold = e.exp;
                end
                busy_cnt = 0;
                own_cnt  = 0;
            end else begin
                chk("result_hold", Result, hold);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 200) begin
            step();
            n++;
        end
        if (Busy) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int at);
        exp_t e;
        e.op  = op;
        e.exp = ref_result(op, a, b);
        e.cyc = at;
        e.lat = ref_latency(op, a, b);
        sb.push_back(e);
    endtask

    // Drive one request for one cycle, then scramble inputs.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        push(op, a, b, cyc);
        step();
        Start = 1'b0;
        Op    = 2'($urandom);
        SrcA  = $urandom;
        SrcB  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            step();
            n++;
        end
        step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        Op    = '0;
        SrcA  = '0;
        SrcB  = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_result", Result, '0);
        chk("rst_aluown", {31'd0, ALUOwn}, 32'd0);

        // Directed cases
        issue(MULDIV_MUL,   32'd7, 32'd6);
        issue(MULDIV_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MULDIV_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MULDIV_DIVU,  32'd100, 32'd7);
        issue(MULDIV_REMU,  32'd100, 32'd7);
        issue(MULDIV_DIVU,  32'h8000_0000, 32'd1);
        issue(MULDIV_REMU,  32'hFFFF_FFFF, 32'h8000_0000);
        issue(MULDIV_DIVU,  32'd5, 32'd0);
        issue(MULDIV_REMU,  32'd5, 32'd0);
        issue(MULDIV_MUL,   32'd0, 32'd9);
        issue(MULDIV_MULHU, 32'd9, 32'd0);
        drain();

        // Start pulsed in RUN cycle 10 must be ignored.
        issue(MULDIV_MUL, 32'd1234, 32'd5678);
        repeat (9) step();
        Start = 1'b1;
        Op    = MULDIV_DIVU;
        SrcA  = 32'd77;
        SrcB  = 32'd3;
        step();
        Start = 1'b0;
        drain();

        // Start held: second acceptance 34 cycles after the first.
        wait_idle();
        Start = 1'b1;
        Op    = MULDIV_MUL;
        SrcA  = 32'd3;
        SrcB  = 32'd5;
        push(MULDIV_MUL, 32'd3, 32'd5, cyc);
        push(MULDIV_MUL, 32'd3, 32'd5, cyc + 34);
        repeat (35) step();
        Start = 1'b0;
        drain();

        // Reset during RUN cycle 10 discards the op.
        issue(MULDIV_DIVU, 32'd1000, 32'd9);
        repeat (9) step();
        reset = 1'b1;
        sb.delete();
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_busy", {31'd0, Busy}, 32'd0);
        chk("post_rst_aluown", {31'd0, ALUOwn}, 32'd0);
        chk("post_rst_result", Result, '0);
        chk("post_rst_done", {31'd0, Done}, 32'd0);
        issue(MULDIV_DIVU, 32'd100, 32'd7);
        drain();

        // Randomized traffic with occasional zero / extreme operands.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = '0;
                2: rb = 32'($urandom_range(1, 15));
                3: ra = '1;
                default: ;
            endcase
            issue(rop, ra, rb);
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
